// File: rtl/axi4lite_arbiter_2to1_pkg.sv
// Shared types and constants for the two-master AXI4-Lite arbiter.
package axi4lite_arb_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WRITE = 3'd1,
    WRESP = 3'd2,
    READ  = 3'd3,
    RRESP = 3'd4
  } arb_state_e;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [1:0] DECERR = 2'b11;

endpackage

// File: rtl/axi4lite_arbiter_2to1_if.sv
// Bundle of both master ports (packed two-wide) and the shared slave port.
interface axi4lite_arbiter_2to1_if #(
  parameter int ADDR = 32,
  parameter int DATA = 32,
  parameter int PROT = 3,
  parameter int RESP = 2,
  parameter int STRB = 4
);
  logic [2*ADDR-1:0] M_AWADDR, M_ARADDR;
  logic [2*PROT-1:0] M_AWPROT, M_ARPROT;
  logic [1:0]        M_AWVALID, M_WVALID, M_ARVALID, M_BREADY, M_RREADY;
  logic [2*DATA-1:0] M_WDATA;
  logic [2*STRB-1:0] M_WSTRB;
  logic [1:0]        M_AWREADY, M_WREADY, M_ARREADY, M_BVALID, M_RVALID;
  logic [RESP-1:0]   M_BRESP, M_RRESP;
  logic [DATA-1:0]   M_RDATA;

  logic [ADDR-1:0]   AXI_AWADDR, AXI_ARADDR;
  logic [PROT-1:0]   AXI_AWPROT, AXI_ARPROT;
  logic [DATA-1:0]   AXI_WDATA;
  logic [STRB-1:0]   AXI_WSTRB;
  logic              AXI_AWVALID, AXI_WVALID, AXI_ARVALID, AXI_BREADY, AXI_RREADY;
  logic              AXI_AWREADY, AXI_WREADY, AXI_ARREADY, AXI_BVALID, AXI_RVALID;
  logic [RESP-1:0]   AXI_BRESP, AXI_RRESP;
  logic [DATA-1:0]   AXI_RDATA;

  // Arbiter view: it masters the shared slave port and serves both masters.
  modport master (
    input  M_AWADDR, M_ARADDR, M_AWPROT, M_ARPROT, M_AWVALID, M_WVALID, M_ARVALID,
           M_BREADY, M_RREADY, M_WDATA, M_WSTRB,
    output M_AWREADY, M_WREADY, M_ARREADY, M_BVALID, M_RVALID, M_BRESP, M_RRESP, M_RDATA,
    output AXI_AWADDR, AXI_ARADDR, AXI_AWPROT, AXI_ARPROT, AXI_WDATA, AXI_WSTRB,
           AXI_AWVALID, AXI_WVALID, AXI_ARVALID, AXI_BREADY, AXI_RREADY,
    input  AXI_AWREADY, AXI_WREADY, AXI_ARREADY, AXI_BVALID, AXI_RVALID,
           AXI_BRESP, AXI_RRESP, AXI_RDATA
  );

  // Environment view: the two masters plus the downstream slave.
  modport slave (
    output M_AWADDR, M_ARADDR, M_AWPROT, M_ARPROT, M_AWVALID, M_WVALID, M_ARVALID,
           M_BREADY, M_RREADY, M_WDATA, M_WSTRB,
    input  M_AWREADY, M_WREADY, M_ARREADY, M_BVALID, M_RVALID, M_BRESP, M_RRESP, M_RDATA,
    input  AXI_AWADDR, AXI_ARADDR, AXI_AWPROT, AXI_ARPROT, AXI_WDATA, AXI_WSTRB,
           AXI_AWVALID, AXI_WVALID, AXI_ARVALID, AXI_BREADY, AXI_RREADY,
    output AXI_AWREADY, AXI_WREADY, AXI_ARREADY, AXI_BVALID, AXI_RVALID,
           AXI_BRESP, AXI_RRESP, AXI_RDATA
  );
endinterface

// File: rtl/axi4lite_arbiter_2to1_rr_pick.sv
// Two-way round-robin pick: the master not served last wins a tie.
module axi4lite_rr_pick (
  input  logic [1:0] req,
  input  logic       rr_last,
  output logic       gnt_idx,
  output logic       any
);

  assign any     = |req;
  assign gnt_idx = (req == 2'b11) ? ~rr_last : req[1];

endmodule

// File: rtl/axi4lite_arbiter_2to1.sv
// Shares one AXI4-Lite slave port between two masters, one transaction per grant.
// state | meaning
// IDLE  | no grant held; pick a master and an operation
// WRITE | AW and W channels open to the granted master
// WRESP | waiting for the B handshake
// READ  | AR channel open to the granted master
// RRESP | waiting for the R handshake
module axi4lite_arbiter_2to1
  import axi4lite_arb_pkg::*;
#(
  parameter int ADDR = 32,
  parameter int DATA = 32,
  parameter int PROT = 3,
  parameter int RESP = 2,
  parameter int STRB = 4
) (
  input  logic                          ACLK,
  input  logic                          ARESETN,
  axi4lite_arbiter_2to1_if.master       bus,
  output logic                          GRANT,
  output logic                          BUSY
);

  arb_state_e state;
  logic       rr_last, last_op_wr, aw_done, w_done;
  logic       pick_idx, pick_any, pick_wr;
  logic       aw_hs, w_hs, b_hs, ar_hs, r_hs;
  logic       axi_awvalid, axi_wvalid, axi_arvalid, axi_bready, axi_rready;
  logic [1:0] m_awready, m_wready, m_arready, m_bvalid, m_rvalid;

  axi4lite_rr_pick u_pick (
    .req     (bus.M_AWVALID | bus.M_ARVALID),
    .rr_last (rr_last),
    .gnt_idx (pick_idx),
    .any     (pick_any)
  );

  // A master holding both valids alternates, steered by the last operation served.
  assign pick_wr = bus.M_AWVALID[pick_idx] & (~bus.M_ARVALID[pick_idx] | ~last_op_wr);

  always_comb begin
    axi_awvalid = 1'b0;
    axi_wvalid  = 1'b0;
    axi_arvalid = 1'b0;
    axi_bready  = 1'b0;
    axi_rready  = 1'b0;
    m_awready   = 2'b00;
    m_wready    = 2'b00;
    m_arready   = 2'b00;
    m_bvalid    = 2'b00;
    m_rvalid    = 2'b00;
    case (state)
      WRITE: begin
        axi_awvalid      = bus.M_AWVALID[GRANT] & ~aw_done;
        axi_wvalid       = bus.M_WVALID[GRANT] & ~w_done;
        m_awready[GRANT] = bus.AXI_AWREADY & ~aw_done;
        m_wready[GRANT]  = bus.AXI_WREADY & ~w_done;
      end
      WRESP: begin
        axi_bready      = bus.M_BREADY[GRANT];
        m_bvalid[GRANT] = bus.AXI_BVALID;
      end
      READ: begin
        axi_arvalid      = bus.M_ARVALID[GRANT];
        m_arready[GRANT] = bus.AXI_ARREADY;
      end
      RRESP: begin
        axi_rready      = bus.M_RREADY[GRANT];
        m_rvalid[GRANT] = bus.AXI_RVALID;
      end
      default: ;
    endcase
  end

  assign aw_hs = axi_awvalid & bus.AXI_AWREADY;
  assign w_hs  = axi_wvalid & bus.AXI_WREADY;
  assign b_hs  = axi_bready & bus.AXI_BVALID;
  assign ar_hs = axi_arvalid & bus.AXI_ARREADY;
  assign r_hs  = axi_rready & bus.AXI_RVALID;

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state      <= IDLE;
      GRANT      <= 1'b0;
      rr_last    <= 1'b1;
      last_op_wr <= 1'b0;
      aw_done    <= 1'b0;
      w_done     <= 1'b0;
    end else begin
      case (state)
        IDLE: if (pick_any) begin
          GRANT <= pick_idx;
          state <= pick_wr ? WRITE : READ;
        end
        WRITE: begin
          if ((aw_done | aw_hs) && (w_done | w_hs)) begin
            state   <= WRESP;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
          end else begin
            if (aw_hs) aw_done <= 1'b1;
            if (w_hs)  w_done  <= 1'b1;
          end
        end
        WRESP: if (b_hs) begin
          state      <= IDLE;
          rr_last    <= GRANT;
          last_op_wr <= 1'b1;
        end
        READ: if (ar_hs) state <= RRESP;
        RRESP: if (r_hs) begin
          state      <= IDLE;
          rr_last    <= GRANT;
          last_op_wr <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign BUSY = (state != IDLE);

  assign bus.AXI_AWVALID = axi_awvalid;
  assign bus.AXI_WVALID  = axi_wvalid;
  assign bus.AXI_ARVALID = axi_arvalid;
  assign bus.AXI_BREADY  = axi_bready;
  assign bus.AXI_RREADY  = axi_rready;
  assign bus.M_AWREADY   = m_awready;
  assign bus.M_WREADY    = m_wready;
  assign bus.M_ARREADY   = m_arready;
  assign bus.M_BVALID    = m_bvalid;
  assign bus.M_RVALID    = m_rvalid;

  assign bus.AXI_AWADDR = GRANT ? bus.M_AWADDR[ADDR +: ADDR] : bus.M_AWADDR[0 +: ADDR];
  assign bus.AXI_ARADDR = GRANT ? bus.M_ARADDR[ADDR +: ADDR] : bus.M_ARADDR[0 +: ADDR];
  assign bus.AXI_AWPROT = GRANT ? bus.M_AWPROT[PROT +: PROT] : bus.M_AWPROT[0 +: PROT];
  assign bus.AXI_ARPROT = GRANT ? bus.M_ARPROT[PROT +: PROT] : bus.M_ARPROT[0 +: PROT];
  assign bus.AXI_WDATA  = GRANT ? bus.M_WDATA[DATA +: DATA]  : bus.M_WDATA[0 +: DATA];
  assign bus.AXI_WSTRB  = GRANT ? bus.M_WSTRB[STRB +: STRB]  : bus.M_WSTRB[0 +: STRB];

  assign bus.M_BRESP = bus.AXI_BRESP[RESP-1:0];
  assign bus.M_RRESP = bus.AXI_RRESP[RESP-1:0];
  assign bus.M_RDATA = bus.AXI_RDATA[DATA-1:0];

endmodule

// File: tb/tb_axi4lite_arbiter_2to1.sv
// Directed bench for the two-master AXI4-Lite arbiter; slave side driven by hand.
module tb_axi4lite_arbiter_2to1;
  import axi4lite_arb_pkg::*;

  logic aclk = 1'b0;
  logic aresetn;
  logic grant, busy;
  int   checks = 0;
  int   failures = 0;
  int   aw_cnt = 0, w_cnt = 0;
  int   aw0, w0;
  logic [31:0] aw_addr_cap, w_data_cap;

  axi4lite_arbiter_2to1_if bus ();

  axi4lite_arbiter_2to1 dut (
    .ACLK    (aclk),
    .ARESETN (aresetn),
    .bus     (bus.master),
    .GRANT   (grant),
    .BUSY    (busy)
  );

  always #5 aclk = ~aclk;

  always @(posedge aclk) begin
    if (bus.AXI_AWVALID && bus.AXI_AWREADY) begin
      aw_cnt      <= aw_cnt + 1;
      aw_addr_cap <= bus.AXI_AWADDR;
    end
    if (bus.AXI_WVALID && bus.AXI_WREADY) begin
      w_cnt      <= w_cnt + 1;
      w_data_cap <= bus.AXI_WDATA;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge aclk);
    #1;
  endtask

  task automatic mid();
    @(negedge aclk);
  endtask

  task automatic clear_inputs();
    bus.M_AWADDR = '0; bus.M_ARADDR = '0; bus.M_AWPROT = '0; bus.M_ARPROT = '0;
    bus.M_AWVALID = '0; bus.M_WVALID = '0; bus.M_ARVALID = '0;
    bus.M_BREADY = '0; bus.M_RREADY = '0; bus.M_WDATA = '0; bus.M_WSTRB = '0;
    bus.AXI_AWREADY = 1'b0; bus.AXI_WREADY = 1'b0; bus.AXI_ARREADY = 1'b0;
    bus.AXI_BVALID = 1'b0; bus.AXI_RVALID = 1'b0;
    bus.AXI_BRESP = OKAY; bus.AXI_RRESP = OKAY; bus.AXI_RDATA = '0;
  endtask

  initial begin
    clear_inputs();
    aresetn = 1'b0;
    // Reset with everything asserted: nothing may leak through.
    bus.M_AWVALID = 2'b11; bus.M_WVALID = 2'b11; bus.M_ARVALID = 2'b11;
    bus.M_BREADY = 2'b11; bus.M_RREADY = 2'b11;
    bus.AXI_AWREADY = 1'b1; bus.AXI_WREADY = 1'b1; bus.AXI_ARREADY = 1'b1;
    bus.AXI_BVALID = 1'b1; bus.AXI_RVALID = 1'b1;
    repeat (2) cyc();
    mid();
    chk("rst_awvalid", {31'd0, bus.AXI_AWVALID}, 32'd0);
    chk("rst_wvalid",  {31'd0, bus.AXI_WVALID},  32'd0);
    chk("rst_arvalid", {31'd0, bus.AXI_ARVALID}, 32'd0);
    chk("rst_bready",  {31'd0, bus.AXI_BREADY},  32'd0);
    chk("rst_rready",  {31'd0, bus.AXI_RREADY},  32'd0);
    chk("rst_m_awready", {30'd0, bus.M_AWREADY}, 32'd0);
    chk("rst_m_wready",  {30'd0, bus.M_WREADY},  32'd0);
    chk("rst_m_arready", {30'd0, bus.M_ARREADY}, 32'd0);
    chk("rst_m_bvalid",  {30'd0, bus.M_BVALID},  32'd0);
    chk("rst_m_rvalid",  {30'd0, bus.M_RVALID},  32'd0);
    chk("rst_grant", {31'd0, grant}, 32'd0);
    chk("rst_busy",  {31'd0, busy},  32'd0);
    cyc();
    clear_inputs();
    aresetn = 1'b1;

    // M0 single write, slave readies two cycles late.
    cyc();
    bus.M_AWADDR[31:0] = 32'h4000_0010; bus.M_WDATA[31:0] = 32'hDEAD_BEEF;
    bus.M_WSTRB[3:0] = 4'hF; bus.M_AWVALID = 2'b01; bus.M_WVALID = 2'b01; bus.M_BREADY = 2'b01;
    mid();
    chk("wr0_latency_awvalid", {31'd0, bus.AXI_AWVALID}, 32'd0);
    cyc();
    mid();
    chk("wr0_awvalid", {31'd0, bus.AXI_AWVALID}, 32'd1);
    chk("wr0_awaddr",  bus.AXI_AWADDR, 32'h4000_0010);
    chk("wr0_wvalid",  {31'd0, bus.AXI_WVALID}, 32'd1);
    chk("wr0_wdata",   bus.AXI_WDATA, 32'hDEAD_BEEF);
    chk("wr0_wstrb",   {28'd0, bus.AXI_WSTRB}, 32'hF);
    chk("wr0_m_awready_wait", {30'd0, bus.M_AWREADY}, 32'd0);
    chk("wr0_busy", {31'd0, busy}, 32'd1);
    cyc();
    bus.AXI_AWREADY = 1'b1; bus.AXI_WREADY = 1'b1;
    mid();
    chk("wr0_m_awready", {30'd0, bus.M_AWREADY}, 32'd1);
    chk("wr0_m_wready",  {30'd0, bus.M_WREADY},  32'd1);
    cyc();
    bus.M_AWVALID = 2'b00; bus.M_WVALID = 2'b00;
    bus.AXI_AWREADY = 1'b0; bus.AXI_WREADY = 1'b0;
    bus.AXI_BVALID = 1'b1; bus.AXI_BRESP = OKAY;
    mid();
    chk("wr0_m_bvalid", {30'd0, bus.M_BVALID}, 32'd1);
    chk("wr0_m_bresp",  {30'd0, bus.M_BRESP},  32'd0);
    chk("wr0_bready",   {31'd0, bus.AXI_BREADY}, 32'd1);
    chk("wr0_awvalid_off", {31'd0, bus.AXI_AWVALID}, 32'd0);
    cyc();
    bus.AXI_BVALID = 1'b0; bus.M_BREADY = 2'b00;
    mid();
    chk("wr0_idle_busy", {31'd0, busy}, 32'd0);
    chk("wr0_aw_count", aw_cnt, 32'd1);
    chk("wr0_w_count",  w_cnt,  32'd1);
    chk("wr0_aw_cap",   aw_addr_cap, 32'h4000_0010);
    chk("wr0_w_cap",    w_data_cap,  32'hDEAD_BEEF);

    // Fresh reset, then simultaneous M0 write and M1 read: M0 goes first.
    aresetn = 1'b0;
    cyc();
    aresetn = 1'b1;
    cyc();
    bus.M_AWADDR[31:0] = 32'h4000_0030; bus.M_WDATA[31:0] = 32'h0000_0011;
    bus.M_AWVALID = 2'b01; bus.M_WVALID = 2'b01; bus.M_BREADY = 2'b01;
    bus.M_ARADDR[63:32] = 32'h4000_0020; bus.M_ARVALID = 2'b10; bus.M_RREADY = 2'b10;
    bus.AXI_AWREADY = 1'b1; bus.AXI_WREADY = 1'b1; bus.AXI_ARREADY = 1'b1;
    cyc();
    mid();
    chk("mix_grant_wr", {31'd0, grant}, 32'd0);
    chk("mix_awvalid", {31'd0, bus.AXI_AWVALID}, 32'd1);
    chk("mix_arvalid_blocked", {31'd0, bus.AXI_ARVALID}, 32'd0);
    chk("mix_m_arready_blocked", {30'd0, bus.M_ARREADY}, 32'd0);
    cyc();
    bus.M_AWVALID = 2'b00; bus.M_WVALID = 2'b00; bus.AXI_BVALID = 1'b1;
    mid();
    chk("mix_m_bvalid", {30'd0, bus.M_BVALID}, 32'd1);
    cyc();
    bus.AXI_BVALID = 1'b0; bus.M_BREADY = 2'b00;
    mid();
    chk("mix_gap_busy", {31'd0, busy}, 32'd0);
    cyc();
    mid();
    chk("mix_grant_rd", {31'd0, grant}, 32'd1);
    chk("mix_arvalid", {31'd0, bus.AXI_ARVALID}, 32'd1);
    chk("mix_araddr", bus.AXI_ARADDR, 32'h4000_0020);
    chk("mix_m_arready", {30'd0, bus.M_ARREADY}, 32'd2);
    cyc();
    bus.M_ARVALID = 2'b00; bus.AXI_ARREADY = 1'b0;
    bus.AXI_RVALID = 1'b1; bus.AXI_RDATA = 32'h1234_5678; bus.AXI_RRESP = OKAY;
    mid();
    chk("mix_m_rvalid", {30'd0, bus.M_RVALID}, 32'd2);
    chk("mix_m_rdata", bus.M_RDATA, 32'h1234_5678);
    chk("mix_rready", {31'd0, bus.AXI_RREADY}, 32'd1);
    cyc();
    clear_inputs();

    // Both masters write continuously: strict alternation, one IDLE between.
    bus.M_AWADDR = {32'h4000_1100, 32'h4000_0100};
    bus.M_AWVALID = 2'b11; bus.M_WVALID = 2'b11; bus.M_BREADY = 2'b11;
    bus.AXI_AWREADY = 1'b1; bus.AXI_WREADY = 1'b1; bus.AXI_BVALID = 1'b1;
    for (int k = 0; k < 8; k++) begin
      mid();
      chk($sformatf("rr%0d_idle", k), {31'd0, busy}, 32'd0);
      cyc();
      mid();
      chk($sformatf("rr%0d_grant", k), {31'd0, grant}, (k % 2));
      chk($sformatf("rr%0d_awaddr", k), bus.AXI_AWADDR, (k % 2) ? 32'h4000_1100 : 32'h4000_0100);
      chk($sformatf("rr%0d_m_awready", k), {30'd0, bus.M_AWREADY}, (k % 2) ? 32'd2 : 32'd1);
      cyc();
      mid();
      chk($sformatf("rr%0d_m_bvalid", k), {30'd0, bus.M_BVALID}, (k % 2) ? 32'd2 : 32'd1);
      cyc();
    end
    clear_inputs();

    // M1 write: W accepted in cycle 1, AW in cycle 3; W must stay masked after.
    bus.M_AWADDR[63:32] = 32'h4000_2000; bus.M_WDATA[63:32] = 32'hA5A5_5A5A;
    bus.M_WSTRB[7:4] = 4'h3; bus.M_AWVALID = 2'b10; bus.M_WVALID = 2'b10; bus.M_BREADY = 2'b10;
    aw0 = aw_cnt; w0 = w_cnt;
    cyc();
    bus.AXI_WREADY = 1'b1;
    mid();
    chk("split_grant", {31'd0, grant}, 32'd1);
    chk("split_c1_wvalid", {31'd0, bus.AXI_WVALID}, 32'd1);
    chk("split_c1_m_wready", {30'd0, bus.M_WREADY}, 32'd2);
    chk("split_c1_m_awready", {30'd0, bus.M_AWREADY}, 32'd0);
    chk("split_wstrb", {28'd0, bus.AXI_WSTRB}, 32'h3);
    chk("split_wdata", bus.AXI_WDATA, 32'hA5A5_5A5A);
    cyc();
    mid();
    chk("split_c2_wvalid", {31'd0, bus.AXI_WVALID}, 32'd0);
    chk("split_c2_m_wready", {30'd0, bus.M_WREADY}, 32'd0);
    chk("split_c2_awvalid", {31'd0, bus.AXI_AWVALID}, 32'd1);
    chk("split_c2_m_bvalid", {30'd0, bus.M_BVALID}, 32'd0);
    cyc();
    bus.AXI_AWREADY = 1'b1;
    mid();
    chk("split_c3_m_awready", {30'd0, bus.M_AWREADY}, 32'd2);
    chk("split_c3_wvalid", {31'd0, bus.AXI_WVALID}, 32'd0);
    cyc();
    bus.M_AWVALID = 2'b00; bus.M_WVALID = 2'b00;
    bus.AXI_AWREADY = 1'b0; bus.AXI_WREADY = 1'b0;
    bus.AXI_BVALID = 1'b1; bus.AXI_BRESP = SLVERR;
    mid();
    chk("split_m_bvalid", {30'd0, bus.M_BVALID}, 32'd2);
    chk("split_m_bresp", {30'd0, bus.M_BRESP}, {30'd0, SLVERR});
    chk("split_aw_count", aw_cnt - aw0, 32'd1);
    chk("split_w_count", w_cnt - w0, 32'd1);
    chk("split_aw_cap", aw_addr_cap, 32'h4000_2000);
    cyc();
    clear_inputs();

    // M1 write stalled in WRESP, then async reset mid-cycle.
    bus.M_AWADDR[63:32] = 32'h4000_0040; bus.M_AWVALID = 2'b10; bus.M_WVALID = 2'b10;
    bus.AXI_AWREADY = 1'b1; bus.AXI_WREADY = 1'b1;
    cyc();
    cyc();
    bus.M_AWVALID = 2'b00; bus.M_WVALID = 2'b00;
    bus.AXI_AWREADY = 1'b0; bus.AXI_WREADY = 1'b0; bus.AXI_BVALID = 1'b1;
    mid();
    chk("arst_pre_m_bvalid", {30'd0, bus.M_BVALID}, 32'd2);
    chk("arst_pre_grant", {31'd0, grant}, 32'd1);
    #2;
    aresetn = 1'b0;
    #1;
    chk("arst_m_bvalid", {30'd0, bus.M_BVALID}, 32'd0);
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_grant", {31'd0, grant}, 32'd0);
    cyc();
    aresetn = 1'b1;
    bus.AXI_BVALID = 1'b0;
    bus.M_ARADDR[63:32] = 32'h4000_0050; bus.M_ARVALID = 2'b10; bus.M_RREADY = 2'b10;
    bus.AXI_ARREADY = 1'b1;
    cyc();
    mid();
    chk("arst_rd_grant", {31'd0, grant}, 32'd1);
    chk("arst_rd_arvalid", {31'd0, bus.AXI_ARVALID}, 32'd1);
    chk("arst_rd_araddr", bus.AXI_ARADDR, 32'h4000_0050);
    cyc();
    bus.M_ARVALID = 2'b00; bus.AXI_ARREADY = 1'b0;
    bus.AXI_RVALID = 1'b1; bus.AXI_RDATA = 32'hCAFE_F00D; bus.AXI_RRESP = DECERR;
    mid();
    chk("arst_rd_m_rvalid", {30'd0, bus.M_RVALID}, 32'd2);
    chk("arst_rd_rdata", bus.M_RDATA, 32'hCAFE_F00D);
    chk("arst_rd_rresp", {30'd0, bus.M_RRESP}, {30'd0, DECERR});
    cyc();
    bus.AXI_RVALID = 1'b0; bus.M_RREADY = 2'b00;
    mid();
    chk("arst_rd_done_busy", {31'd0, busy}, 32'd0);
    chk("arst_rd_done_rvalid", {30'd0, bus.M_RVALID}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
